equiv_checker: RTL and testbench

EQUIV_CHECKER -- requirements
Module: equiv_checker

---
 rtl/equiv_checker.sv | 127 ++++++++++++
 tb/tb_equiv_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_checker.sv
// Exhaustive equivalence checker: sweeps every minterm of NVARS inputs, samples
// two combinational expressions F and G, and reports their truth tables and differences.
module equiv_checker #(
    parameter int NVARS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  f_in,
    input  logic                  g_in,
    output logic [NVARS-1:0]      vars_out,
    output logic                  busy,
    output logic                  done,
    output logic                  equal,
    output logic [NVARS:0]        mismatch_cnt,
    output logic [NVARS-1:0]      first_bad,
    output logic [2**NVARS-1:0]   truth_f,
    output logic [2**NVARS-1:0]   truth_g
);

    localparam int NMIN = 2**NVARS;
    localparam logic [NVARS-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [NVARS-1:0]  vars_q, vars_d;
    logic [NVARS:0]    cnt_q, cnt_d;
    logic [NVARS-1:0]  firstBad_q, firstBad_d;
    logic [NMIN-1:0]   tf_q, tf_d;
    logic [NMIN-1:0]   tg_q, tg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              equal_q, equal_d;
    logic              diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vars_q     <= '0;
            cnt_q      <= '0;
            firstBad_q <= '0;
            tf_q       <= '0;
            tg_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            equal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vars_q     <= vars_d;
            cnt_q      <= cnt_d;
            firstBad_q <= firstBad_d;
            tf_q       <= tf_d;
            tg_q       <= tg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            equal_q    <= equal_d;
        end
    end

    // Results are published one cycle after the last sample so equal sees the final count;
    // busy stays high for that cycle, which also keeps a start there from being accepted.
    always_comb begin
        state_d    = state_q;
        vars_d     = vars_q;
        cnt_d      = cnt_q;
        firstBad_d = firstBad_q;
        tf_d       = tf_q;
        tg_d       = tg_q;
        busy_d     = busy_q;
        done_d     = done_q;
        equal_d    = equal_q;
        diff       = (f_in !== g_in);

        unique case (state_q)
            IDLE, DONE: begin
                if (busy_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    equal_d = (cnt_q == '0);
                end else if (start) begin
                    state_d    = DRIVE;
                    vars_d     = '0;
                    cnt_d      = '0;
                    firstBad_d = '0;
                    tf_d       = '0;
                    tg_d       = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    equal_d    = 1'b0;
                end
            end
            DRIVE: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                tf_d[vars_q] = f_in;
                tg_d[vars_q] = g_in;
                if (diff) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        firstBad_d = vars_q;
                    end
                end
                if (vars_q == LAST) begin
                    state_d = DONE;
                end else begin
                    vars_d  = vars_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vars_out     = vars_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign equal        = equal_q;
    assign mismatch_cnt = cnt_q;
    assign first_bad    = firstBad_q;
    assign truth_f      = tf_q;
    assign truth_g      = tg_q;

endmodule

// File: tb/tb_equiv_checker.sv
// Scoreboard bench: two checker instances (NVARS=2 and NVARS=4) driven by directed
// expression pairs; monitors pop expected results whenever done rises.
module tb_equiv_checker;

    typedef struct {
        logic        eq;
        logic [4:0]  cnt;
        logic [3:0]  fb;
        bit          checkFb;
        logic [15:0] tf;
        logic [15:0] tg;
        int          doneEdge;
    } exp_t;

    logic clk;
    logic rst;
    logic start2, start4;
    logic f2, g2, f4, g4;
    logic xVal;
    int   mode2, mode4;
    int   edgeCnt;
    int   checks;
    int   errors;

    logic [1:0]  vars2;
    logic        busy2, done2, equal2;
    logic [2:0]  cnt2;
    logic [1:0]  fb2;
    logic [3:0]  tf2, tg2;

    logic [3:0]  vars4;
    logic        busy4, done4, equal4;
    logic [4:0]  cnt4;
    logic [3:0]  fb4;
    logic [15:0] tf4, tg4;

    exp_t exp2Q[$];
    exp_t exp4Q[$];

    equiv_checker #(.NVARS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .f_in(f2), .g_in(g2),
        .vars_out(vars2), .busy(busy2), .done(done2), .equal(equal2),
        .mismatch_cnt(cnt2), .first_bad(fb2), .truth_f(tf2), .truth_g(tg2)
    );

    equiv_checker #(.NVARS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .f_in(f4), .g_in(g4),
        .vars_out(vars4), .busy(busy4), .done(done4), .equal(equal4),
        .mismatch_cnt(cnt4), .first_bad(fb4), .truth_f(tf4), .truth_g(tg4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial edgeCnt = 0;
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Expressions under test, x = MSB of vars
    always_comb begin
        f2 = 1'b0;
        g2 = 1'b0;
        case (mode2)
            0: begin
                f2 = ~(~vars2[0] | ~vars2[1]) & (vars2[0] | ~vars2[1]);
                g2 = vars2[1] & vars2[0];
            end
            1: begin
                f2 = vars2[1] | vars2[0];
                g2 = vars2[1] & vars2[0];
            end
            2: begin
                f2 = ~vars2[1];
                g2 = vars2[1];
            end
            3: begin
                f2 = xVal;
                g2 = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        f4 = vars4[3] ^ vars4[2] ^ vars4[1] ^ vars4[0];
        g4 = vars4[3] ^ vars4[2] ^ vars4[1] ^ vars4[0];
        if (mode4 == 1) begin
            g4 = ~(vars4[3] ^ vars4[2] ^ vars4[1] ^ vars4[0]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic compareResult(input string tag, input exp_t e, input int edgeNow,
                                 input logic eq, input logic [4:0] cnt, input logic [3:0] fb,
                                 input logic [15:0] tf, input logic [15:0] tg);
        checkOutput({tag, " done latency"}, edgeNow, e.doneEdge);
        checkOutput({tag, " equal"}, {31'b0, eq}, {31'b0, e.eq});
        checkOutput({tag, " mismatch_cnt"}, {27'b0, cnt}, {27'b0, e.cnt});
        checkOutput({tag, " truth_f"}, {16'b0, tf}, {16'b0, e.tf});
        checkOutput({tag, " truth_g"}, {16'b0, tg}, {16'b0, e.tg});
        if (e.checkFb) begin
            checkOutput({tag, " first_bad"}, {28'b0, fb}, {28'b0, e.fb});
        end
    endtask

    initial begin : monitor2
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done2 && !prev) begin
                if (exp2Q.size() == 0) begin
                    checkOutput("dut2 unexpected done", {31'b0, done2}, 32'd0);
                end else begin
                    e = exp2Q.pop_front();
                    compareResult("dut2", e, edgeCnt, equal2, {2'b0, cnt2}, {2'b0, fb2},
                                  {12'b0, tf2}, {12'b0, tg2});
                end
            end
            prev = done2;
        end
    end

    initial begin : monitor4
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done4 && !prev) begin
                if (exp4Q.size() == 0) begin
                    checkOutput("dut4 unexpected done", {31'b0, done4}, 32'd0);
                end else begin
                    e = exp4Q.pop_front();
                    compareResult("dut4", e, edgeCnt, equal4, cnt4, fb4, tf4, tg4);
                end
            end
            prev = done4;
        end
    end

    // Called at a negedge; start is sampled on the next rising edge (edge k)
    task automatic applyStimulus(input int unit, input int mode, input bit push,
                                 input logic eq, input logic [4:0] cnt, input logic [3:0] fb,
                                 input bit checkFb, input logic [15:0] tf, input logic [15:0] tg);
        exp_t e;
        e.eq = eq;
        e.cnt = cnt;
        e.fb = fb;
        e.checkFb = checkFb;
        e.tf = tf;
        e.tg = tg;
        if (unit == 2) begin
            mode2 = mode;
            start2 = 1'b1;
            e.doneEdge = edgeCnt + 1 + 2 * 4 + 1;
            if (push) exp2Q.push_back(e);
        end else begin
            mode4 = mode;
            start4 = 1'b1;
            e.doneEdge = edgeCnt + 1 + 2 * 16 + 1;
            if (push) exp4Q.push_back(e);
        end
        @(negedge clk);
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic waitResults(input int budget);
        for (int i = 0; i < budget && (exp2Q.size() + exp4Q.size()) != 0; i++) begin
            @(negedge clk);
        end
        checkOutput("pending results", exp2Q.size() + exp4Q.size(), 0);
        exp2Q.delete();
        exp4Q.delete();
    endtask

    initial begin
        logic [4:0] xCnt;
        checks = 0;
        errors = 0;
        mode2 = 0;
        mode4 = 0;
        start2 = 1'b0;
        start4 = 1'b0;
        xVal = 1'bx;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {30'b0, busy2, busy4}, 32'd0);
        checkOutput("reset done", {30'b0, done2, done4}, 32'd0);
        checkOutput("reset equal", {30'b0, equal2, equal4}, 32'd0);
        checkOutput("reset vars", {26'b0, vars2, vars4}, 32'd0);
        checkOutput("reset cnt", {24'b0, cnt2, cnt4}, 32'd0);
        checkOutput("reset truth", {tf2, tg2, tf4[7:0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(2, 0, 1'b1, 1'b1, 5'd0, 4'd0, 1'b0, 16'h0008, 16'h0008);
        waitResults(100);
        repeat (5) @(negedge clk);
        checkOutput("hold done", {31'b0, done2}, 32'd1);
        checkOutput("hold truth_f", {28'b0, tf2}, 32'h8);
        checkOutput("hold vars no wrap", {30'b0, vars2}, 32'd3);

        applyStimulus(2, 1, 1'b1, 1'b0, 5'd2, 4'd1, 1'b1, 16'h000E, 16'h0008);
        waitResults(100);

        applyStimulus(2, 2, 1'b1, 1'b0, 5'd4, 4'd0, 1'b1, 16'h0003, 16'h000C);
        waitResults(100);

        xCnt = (xVal !== 1'b0) ? 5'd4 : 5'd0;
        applyStimulus(2, 3, 1'b1, (xCnt == 5'd0), xCnt, 4'd0, (xCnt != 5'd0),
                      {12'b0, {4{xVal}}}, 16'h0000);
        waitResults(100);

        // A second start mid-sweep must not disturb the results or the latency
        applyStimulus(2, 1, 1'b1, 1'b0, 5'd2, 4'd1, 1'b1, 16'h000E, 16'h0008);
        repeat (2) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        waitResults(100);

        // Restart at sweep cycle 3 then reset at cycle 5
        applyStimulus(2, 0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy/done", {30'b0, busy2, done2}, 32'd0);
        checkOutput("abort results", {19'b0, equal2, cnt2, fb2, vars2, tf2[0]}, 32'd0);
        checkOutput("abort truth", {24'b0, tf2, tg2}, 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("stay idle", {27'b0, busy2, done2, vars2, equal2}, 32'd0);

        // Reset wins over a simultaneous start
        start2 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        rst = 1'b0;
        checkOutput("rst priority busy", {31'b0, busy2}, 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("rst priority idle", {30'b0, busy2, done2}, 32'd0);

        applyStimulus(4, 0, 1'b1, 1'b1, 5'd0, 4'd0, 1'b0, 16'h6996, 16'h6996);
        waitResults(100);

        applyStimulus(4, 1, 1'b1, 1'b0, 5'd16, 4'd0, 1'b1, 16'h6996, 16'h9669);
        waitResults(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
